// File: rtl/data_mem_rv.sv
// Byte-addressable RISC-V data memory with valid/ready requests, fixed-latency responses,
// access error flagging and a post-reset clear sweep of the whole array.
module data_mem_rv #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            DEPTH        = 64,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned            READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WinBytes = ADDR_WIDTH'(4 * DEPTH);

  typedef enum logic {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic [31:0]     mem [DEPTH];

  logic [ADDR_WIDTH-1:0] off;
  logic [IdxW-1:0]       idx;
  logic [1:0]            lane;
  logic                  in_win, legal_f3, misal, err, accept, do_write;
  logic [3:0]            be;
  logic [31:0]           wdata_rep, word, shifted, load_val, rdata_d;

  assign req_ready = (state_q == StRun);
  assign init_busy = (state_q == StInit);
  assign accept    = req_valid && req_ready;

  assign off    = req_addr - BASE_ADDR;
  assign idx    = off[IdxW+1:2];
  assign lane   = req_addr[1:0];
  assign in_win = (req_addr >= BASE_ADDR) && (off < WinBytes);

  always_comb begin
    legal_f3 = 1'b0;
    misal    = 1'b0;
    be       = 4'b1111;
    wdata_rep = req_wdata;
    if (req_we) legal_f3 = (req_funct3 <= 3'd2);
    else        legal_f3 = req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    unique case (req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misal     = lane[0];
        be        = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: misal = (lane != 2'b00);
    endcase
  end

  assign err = !in_win || !legal_f3 || misal;
  // A store racing a reset edge must not land in the array.
  assign do_write = accept && req_we && !err && !reset;

  assign word    = mem[idx];
  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    load_val = '0;
    unique case (req_funct3)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    load_val = word;
      3'd4:    load_val = {24'd0, shifted[7:0]};
      3'd5:    load_val = {16'd0, shifted[15:0]};
      default: load_val = '0;
    endcase
  end

  assign rdata_d = (req_we || err) ? '0 : load_val;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + IdxW'(1);
      if (cnt_q == IdxW'(DEPTH - 1)) state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StInit) begin
        mem[cnt_q] <= '0;
      end else if (do_write) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  logic        s1_valid_q, s1_err_q;
  logic [31:0] s1_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_rdata_q <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_err_q   <= accept && err;
      s1_rdata_q <= accept ? rdata_d : '0;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic        s2_valid_q, s2_err_q;
    logic [31:0] s2_rdata_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_rdata_q <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        s2_rdata_q <= s1_rdata_q;
      end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_err   = s2_err_q;
    assign rsp_rdata = s2_rdata_q;
  end else begin : g_lat1
    assign rsp_valid = s1_valid_q;
    assign rsp_err   = s1_err_q;
    assign rsp_rdata = s1_rdata_q;
  end

endmodule

// File: tb/tb_data_mem_rv.sv
// Bench for data_mem_rv: two instances (latency 1 and 2) share stimulus and are checked
// against a byte-array reference model, hand-computed vectors and corner sequences.
module tb_data_mem_rv;

  localparam int unsigned Depth = 64;
  localparam logic [31:0] Base  = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        ready1, busy1, rv1, re1;
  logic        ready2, busy2, rv2, re2;
  logic [31:0] rd1, rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_rv #(.ADDR_WIDTH(32), .DEPTH(Depth), .BASE_ADDR(Base), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .init_busy(busy1)
  );

  data_mem_rv #(.ADDR_WIDTH(32), .DEPTH(Depth), .BASE_ADDR(Base), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2), .init_busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, access rules applied arithmetically.
  logic [7:0] mb [4*Depth];

  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    longint      off;
    int          size;
    logic        legal;
    logic [63:0] v;
    rd = '0;
    er = 1'b0;
    off = longint'(addr) - longint'(Base);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal || off < 0 || off >= longint'(4 * Depth)) begin
      er = 1'b1;
    end else if ((off % size) != 0) begin
      er = 1'b1;
    end else if (we) begin
      for (int i = 0; i < size; i++) mb[int'(off) + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (64'(mb[int'(off) + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
      rd = v[31:0];
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  bit   m_ready = 1'b0;
  int   m_cnt = 0;
  bit   started = 1'b0;

  always @(posedge clk) begin
    logic [31:0] erd;
    logic        eer;
    cyc++;
    started = 1'b1;
    if (reset) begin
      m_ready = 1'b0;
      m_cnt = 0;
      q1.delete();
      q2.delete();
      for (int i = 0; i < 4 * Depth; i++) mb[i] = 8'h00;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == Depth) m_ready = 1'b1;
    end else if (req_valid) begin
      model_access(req_we, req_funct3, req_addr, req_wdata, erd, eer);
      q1.push_back('{cyc, erd, eer});
      q2.push_back('{cyc + 1, erd, eer});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mon_ready1", ready1, m_ready);
      chk("mon_busy1", busy1, !m_ready);
      chk("mon_ready2", ready2, m_ready);
      chk("mon_busy2", busy2, !m_ready);
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("mon_valid1", rv1, 1);
        chk("mon_rdata1", rd1, q1[0].rd);
        chk("mon_err1", re1, q1[0].er);
        void'(q1.pop_front());
      end else begin
        chk("mon_idle1", rv1, 0);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        chk("mon_valid2", rv2, 1);
        chk("mon_rdata2", rd2, q2[0].rd);
        chk("mon_err2", re2, q2[0].er);
        void'(q2.pop_front());
      end else begin
        chk("mon_idle2", rv2, 0);
      end
    end
  end

  task automatic reset_sweep(input bit keep_req);
    int n;
    reset = 1'b1;
    if (!keep_req) req_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready1", ready1, 0);
    chk("rst_busy1", busy1, 1);
    chk("rst_valid1", rv1, 0);
    chk("rst_rdata1", rd1, 0);
    chk("rst_err1", re1, 0);
    chk("rst_ready2", ready2, 0);
    chk("rst_valid2", rv2, 0);
    chk("rst_rdata2", rd2, 0);
    chk("rst_err2", re2, 0);
    reset = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("sweep_cycles", n, Depth);
    chk("ready_after_sweep1", ready1, 1);
    chk("ready_after_sweep2", ready2, 1);
  endtask

  task automatic xact_chk(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] erd, input logic eer);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(negedge clk);
    chk({nm, "_valid1"}, rv1, 1);
    chk({nm, "_rdata1"}, rd1, erd);
    chk({nm, "_err1"}, re1, eer);
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid2"}, rv2, 1);
    chk({nm, "_rdata2"}, rd2, erd);
    chk({nm, "_err2"}, re2, eer);
  endtask

  task automatic lw_all_zero(input string nm);
    for (int w = 0; w < Depth; w++) begin
      xact_chk(nm, 1'b0, 3'd2, Base + 32'(4 * w), 32'd0, 32'd0, 1'b0);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int c1, c2, sz, w, ln;
    logic we;
    logic [2:0] f3;

    vecs[0]  = '{1'b1, 3'd2, 32'h400, 32'h8899_AABB, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 32'h401, 32'h0000_0011, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 32'h400, 32'h0,         32'h8899_11BB, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 32'h403, 32'h0,         32'hFFFF_FF88, 1'b0};
    vecs[4]  = '{1'b0, 3'd4, 32'h403, 32'h0,         32'h0000_0088, 1'b0};
    vecs[5]  = '{1'b0, 3'd1, 32'h402, 32'h0,         32'hFFFF_8899, 1'b0};
    vecs[6]  = '{1'b0, 3'd5, 32'h402, 32'h0,         32'h0000_8899, 1'b0};
    vecs[7]  = '{1'b1, 3'd2, 32'h402, 32'h1111_2222, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 3'd1, 32'h401, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 3'd2, 32'h3FC, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 3'd2, 32'h500, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 3'd3, 32'h400, 32'h0,         32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 3'd3, 32'h400, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 3'd2, 32'h400, 32'h0,         32'h8899_11BB, 1'b0};
    vecs[14] = '{1'b1, 3'd0, 32'h4FF, 32'h0000_00A5, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 3'd4, 32'h4FF, 32'h0,         32'h0000_00A5, 1'b0};
    vecs[16] = '{1'b0, 3'd0, 32'h4FF, 32'h0,         32'hFFFF_FFA5, 1'b0};
    vecs[17] = '{1'b0, 3'd2, 32'h000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[18] = '{1'b1, 3'd1, 32'h406, 32'h1234_BEEF, 32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, 3'd2, 32'h404, 32'h0,         32'hBEEF_0000, 1'b0};

    // A store held valid through reset and the sweep must never be accepted.
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'd2;
    req_addr = Base;
    req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset_sweep(1'b1);
    lw_all_zero("init_lw");

    for (int i = 0; i < 20; i++) begin
      xact_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
               vecs[i].rd, vecs[i].err);
    end

    // Store then load of the same word on consecutive cycles.
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'd2;
    req_addr = 32'h4FC;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("raw_st_valid1", rv1, 1);
    req_we = 1'b0;
    @(negedge clk);
    chk("raw_ld_valid1", rv1, 1);
    chk("raw_ld_rdata1", rd1, 32'h1234_5678);
    chk("raw_st_valid2", rv2, 1);
    chk("raw_st_rdata2", rd2, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("raw_ld_valid2", rv2, 1);
    chk("raw_ld_rdata2", rd2, 32'h1234_5678);
    chk("raw_idle1", rv1, 0);

    // Throughput: legal random requests with valid held high.
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < 100; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 2));
      w  = int'($urandom_range(0, 15));
      ln = (sz == 0) ? int'($urandom_range(0, 3)) : (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
      f3 = 3'(sz);
      if (!we && sz < 2 && $urandom_range(0, 1) == 1) f3 = 3'(sz + 4);
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = Base + 32'(4 * w + ln);
      req_wdata = $urandom;
      @(negedge clk);
      if (rv1) c1++;
      if (rv2) c2++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (rv2) c2++;
    chk("thru_pulses1", c1, 100);
    chk("thru_pulses2", c2, 100);

    // Unconstrained requests around the window, including illegal ones.
    for (int i = 0; i < 100; i++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      req_we = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr = Base - 32'd8 + 32'($urandom_range(0, 4 * Depth + 15));
      req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Fill every word with garbage, then reset and expect a fully cleared array.
    for (int i = 0; i < Depth; i++) begin
      req_valid = 1'b1;
      req_we = 1'b1;
      req_funct3 = 3'd2;
      req_addr = Base + 32'(4 * i);
      req_wdata = $urandom | 32'h1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_sweep(1'b0);
    lw_all_zero("sweep_lw");

    // Reset with responses still in flight in the latency-2 instance.
    xact_chk("mid_st", 1'b1, 3'd2, 32'h480, 32'hCAFE_F00D, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'h480;
    @(negedge clk);
    @(negedge clk);
    chk("mid_ld2_valid1", rv1, 1);
    chk("mid_ld2_rdata1", rd1, 32'hCAFE_F00D);
    reset_sweep(1'b0);
    xact_chk("mid_after", 1'b0, 3'd2, 32'h480, 32'h0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
